// File: rtl/mapu_res_tx.sv
// Result transmitter: captures one DIM x DIM result matrix from the MAPU core
// and streams its elements row-major over a valid/ready interface.
module mapu_res_tx #(
    parameter int DATA_WIDTH = 32,
    parameter int DIM        = 3
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          in_vld,
    output logic                          in_rdy,
    input  logic [DIM*DIM*DATA_WIDTH-1:0] in_mat,
    input  logic                          in_ovf,
    input  logic                          flush,
    output logic                          out_vld,
    input  logic                          out_rdy,
    output logic [DATA_WIDTH-1:0]         out_r,
    output logic                          out_last,
    output logic                          out_ovf,
    output logic                          busy,
    output logic [15:0]                   mat_count
);

    localparam int NEL = DIM * DIM;
    localparam int IW  = $clog2(NEL);
    localparam logic [IW-1:0] LAST = IW'(NEL - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                             state;
    logic [IW-1:0]                      idx;
    logic [NEL-1:0][DATA_WIDTH-1:0]     mat_q;
    logic                               ovf_q;

    // Element mux reads only the captured copy, so in_mat may change freely in SEND.
    assign out_r    = mat_q[idx];
    assign out_last = out_vld && (idx == LAST);
    assign out_ovf  = ovf_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            idx       <= '0;
            mat_q     <= '0;
            ovf_q     <= 1'b0;
            mat_count <= '0;
            in_rdy    <= 1'b1;
            out_vld   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // flush wins over a pending capture
                    if (!flush && in_vld && in_rdy) begin
                        mat_q   <= in_mat;
                        ovf_q   <= in_ovf;
                        idx     <= '0;
                        state   <= SEND;
                        in_rdy  <= 1'b0;
                        out_vld <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                SEND: begin
                    if (flush) begin
                        idx     <= '0;
                        state   <= IDLE;
                        in_rdy  <= 1'b1;
                        out_vld <= 1'b0;
                        busy    <= 1'b0;
                    end else if (out_rdy) begin
                        if (idx == LAST) begin
                            idx       <= '0;
                            state     <= IDLE;
                            mat_count <= mat_count + 16'd1;
                            in_rdy    <= 1'b1;
                            out_vld   <= 1'b0;
                            busy      <= 1'b0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mapu_res_tx.sv
// Self-checking bench for mapu_res_tx: scoreboard of expected elements plus
// directed flush / reset / counter-wrap sequences and a DIM=2 instance.
module tb_mapu_res_tx;

    localparam int DW  = 32;
    localparam int DIM = 3;
    localparam int NEL = DIM * DIM;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                in_vld = 1'b0;
    logic                in_rdy;
    logic [NEL*DW-1:0]   in_mat = '0;
    logic                in_ovf = 1'b0;
    logic                flush = 1'b0;
    logic                out_vld;
    logic                out_rdy = 1'b0;
    logic [DW-1:0]       out_r;
    logic                out_last;
    logic                out_ovf;
    logic                busy;
    logic [15:0]         mat_count;

    logic                in_vld2 = 1'b0;
    logic                in_rdy2;
    logic [4*DW-1:0]     in_mat2 = '0;
    logic                out_vld2;
    logic [DW-1:0]       out_r2;
    logic                out_last2;
    logic                out_ovf2;
    logic                busy2;
    logic [15:0]         mat_count2;

    always #5 clk = ~clk;

    mapu_res_tx #(.DATA_WIDTH(DW), .DIM(DIM)) dut (
        .clk(clk), .reset_n(reset_n), .in_vld(in_vld), .in_rdy(in_rdy),
        .in_mat(in_mat), .in_ovf(in_ovf), .flush(flush), .out_vld(out_vld),
        .out_rdy(out_rdy), .out_r(out_r), .out_last(out_last), .out_ovf(out_ovf),
        .busy(busy), .mat_count(mat_count)
    );

    mapu_res_tx #(.DATA_WIDTH(DW), .DIM(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .in_vld(in_vld2), .in_rdy(in_rdy2),
        .in_mat(in_mat2), .in_ovf(1'b0), .flush(1'b0), .out_vld(out_vld2),
        .out_rdy(1'b1), .out_r(out_r2), .out_last(out_last2), .out_ovf(out_ovf2),
        .busy(busy2), .mat_count(mat_count2)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic          ovf;
    } exp_t;

    typedef struct {
        logic [DW-1:0] base;
        logic          ovf;
        int            rdy_mode;   // 0: always ready, 1: pattern 1,0,0,...
        logic          corrupt;    // scribble in_mat/in_ovf after capture
        logic [15:0]   exp_cnt;
    } vec_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Scoreboard monitor: a transfer happens on the next edge iff vld&rdy now.
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_r = '0;
    logic          prev_last = 1'b0;
    logic          prev_ovf = 1'b0;

    always @(negedge clk) begin
        if (reset_n && !flush && out_vld) begin
            if (prev_stall) begin
                check("stall_r", 64'(out_r), 64'(prev_r));
                check("stall_last", 64'(out_last), 64'(prev_last));
                check("stall_ovf", 64'(out_ovf), 64'(prev_ovf));
            end
            if (out_rdy) begin
                if (sb.size() == 0) begin
                    check("unexpected_xfer", 64'(out_r), 64'hDEAD);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_r", 64'(out_r), 64'(e.data));
                    check("out_last", 64'(out_last), 64'(e.last));
                    check("out_ovf", 64'(out_ovf), 64'(e.ovf));
                end
            end
        end
        prev_stall = reset_n && !flush && out_vld && !out_rdy;
        prev_r     = out_r;
        prev_last  = out_last;
        prev_ovf   = out_ovf;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [DW-1:0] base, input logic ovf);
        int w;
        w = 0;
        while (!in_rdy && w < 20) begin
            tick();
            w++;
        end
        if (!in_rdy) check("wait_in_rdy", 64'(in_rdy), 64'd1);
        for (int k = 0; k < NEL; k++) begin
            exp_t e;
            in_mat[k*DW +: DW] = base + DW'(k);
            e.data = base + DW'(k);
            e.last = (k == NEL - 1);
            e.ovf  = ovf;
            sb.push_back(e);
        end
        in_ovf = ovf;
        in_vld = 1'b1;
        tick();
        in_vld = 1'b0;
        check("latency_vld", 64'(out_vld), 64'd1);
        check("latency_busy", 64'(busy), 64'd1);
    endtask

    task automatic send_matrix(input vec_t v);
        int cyc;
        capture(v.base, v.ovf);
        if (v.corrupt) begin
            in_mat = '1;
            in_ovf = ~v.ovf;
        end
        cyc = 0;
        while (sb.size() != 0 && cyc < 200) begin
            out_rdy = (v.rdy_mode == 0) ? 1'b1 : (cyc % 3 == 0);
            tick();
            cyc++;
        end
        out_rdy = 1'b0;
        if (sb.size() != 0) check("stream_timeout", 64'(sb.size()), 64'd0);
        check("end_in_rdy", 64'(in_rdy), 64'd1);
        check("end_out_vld", 64'(out_vld), 64'd0);
        check("mat_count", 64'(mat_count), 64'(v.exp_cnt));
        in_ovf = 1'b0;
    endtask

    task automatic xfer_n(input int n);
        out_rdy = 1'b1;
        for (int i = 0; i < n; i++) tick();
        out_rdy = 1'b0;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_out_vld"}, 64'(out_vld), 64'd0);
        check({tag, "_out_r"}, 64'(out_r), 64'd0);
        check({tag, "_out_last"}, 64'(out_last), 64'd0);
        check({tag, "_out_ovf"}, 64'(out_ovf), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_mat_count"}, 64'(mat_count), 64'd0);
    endtask

    vec_t vecs[3];

    initial begin
        vec_t v;
        vecs[0] = '{base: 32'd1, ovf: 1'b0, rdy_mode: 0, corrupt: 1'b0, exp_cnt: 16'd1};
        vecs[1] = '{base: 32'd1, ovf: 1'b0, rdy_mode: 1, corrupt: 1'b0, exp_cnt: 16'd2};
        vecs[2] = '{base: 32'd1, ovf: 1'b1, rdy_mode: 1, corrupt: 1'b1, exp_cnt: 16'd3};

        #12;
        check_idle_zero("in_reset");
        reset_n = 1'b1;
        tick();
        check_idle_zero("post_reset");
        check("post_reset_in_rdy", 64'(in_rdy), 64'd1);

        for (int i = 0; i < 3; i++) send_matrix(vecs[i]);

        // flush after the 4th transfer; the transfer offered with flush is dropped
        capture(32'h100, 1'b0);
        xfer_n(4);
        flush = 1'b1;
        out_rdy = 1'b1;
        tick();
        flush = 1'b0;
        out_rdy = 1'b0;
        sb.delete();
        check("flush_out_vld", 64'(out_vld), 64'd0);
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_in_rdy", 64'(in_rdy), 64'd1);
        check("flush_mat_count", 64'(mat_count), 64'd3);
        // flush in IDLE beats in_vld
        flush = 1'b1;
        in_vld = 1'b1;
        tick();
        flush = 1'b0;
        in_vld = 1'b0;
        check("flush_idle_no_capture", 64'(busy), 64'd0);
        v = '{base: 32'h200, ovf: 1'b0, rdy_mode: 0, corrupt: 1'b0, exp_cnt: 16'd4};
        send_matrix(v);

        // reset pulse after the 5th transfer
        capture(32'h300, 1'b1);
        xfer_n(5);
        reset_n = 1'b0;
        #3;
        check_idle_zero("async_reset");
        sb.delete();
        tick();
        reset_n = 1'b1;
        tick();
        check_idle_zero("reset_release");
        check("reset_release_in_rdy", 64'(in_rdy), 64'd1);
        tick();
        check("no_resume_vld", 64'(out_vld), 64'd0);
        v = '{base: 32'd1, ovf: 1'b0, rdy_mode: 0, corrupt: 1'b0, exp_cnt: 16'd1};
        send_matrix(v);

        // counter wrap
        force dut.mat_count = 16'hFFFF;
        #1;
        release dut.mat_count;
        #1;
        check("preload_count", 64'(mat_count), 64'hFFFF);
        v = '{base: 32'h40, ovf: 1'b0, rdy_mode: 1, corrupt: 1'b0, exp_cnt: 16'h0000};
        send_matrix(v);

        // DIM=2 instance: out_last on the 4th element only
        in_mat2 = {32'd4, 32'd3, 32'd2, 32'd1};
        in_vld2 = 1'b1;
        tick();
        in_vld2 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("dim2_vld", 64'(out_vld2), 64'd1);
            check("dim2_r", 64'(out_r2), 64'(k + 1));
            check("dim2_last", 64'(out_last2), 64'(k == 3));
            tick();
        end
        check("dim2_done_vld", 64'(out_vld2), 64'd0);
        check("dim2_in_rdy", 64'(in_rdy2), 64'd1);
        check("dim2_count", 64'(mat_count2), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
